nvdla_slcg_hyst_multi: RTL

Parametrised second-level clock gate controller for NVDLA sub-units. It drives NUM_CH independently gated copies of nvdla_core_clk from a single clock domain. Each channel adds a programmable idle-hysteresis window, so the clock stays on for cfg_hyst_cycles after the channel's last busy cycle. This stops the gate toggling on short idle gaps. Global, DLA and test overrides behave exactly as in the single-channel SLCG; per-channel software force-on is added.

---
 rtl/nvdla_slcg_hyst_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/nvdla_slcg_hyst_multi.sv
// Multi-channel second-level clock gate with per-channel idle hysteresis.
// Each channel keeps its clock running for cfg_hyst_cycles after going idle.
module NV_CLK_gate_power (
   input  logic clk,
   input  logic reset_,
   input  logic clk_en,
   output logic clk_gated
);

   logic en_q;

   // Enable is captured while clk is low, so the AND cannot glitch.
   always_ff @(negedge clk or negedge reset_) begin
      if (!reset_) begin
         en_q <= 1'b0;
      end else begin
         en_q <= clk_en;
      end
   end

   assign clk_gated = clk & en_q;

endmodule

module nvdla_slcg_hyst_multi #(
   parameter int NUM_CH = 4,
   parameter int HYST_W = 8
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic [NUM_CH-1:0] enable,
   input  logic              dla_clk_ovr_on_sync,
   input  logic              global_clk_ovr_on_sync,
   input  logic              tmc2slcg_disable_clock_gating,
   input  logic [HYST_W-1:0] cfg_hyst_cycles,
   input  logic [NUM_CH-1:0] cfg_ch_force_on,
   output logic [NUM_CH-1:0] nvdla_core_gated_clk,
   output logic [NUM_CH-1:0] slcg_en_status,
   output logic              slcg_busy
);

   localparam logic [HYST_W-1:0] HZERO = '0;
   localparam logic [HYST_W-1:0] HONE  = HYST_W'(1);

   logic                           ovr;
   logic [NUM_CH-1:0]              clk_en;
   logic [NUM_CH-1:0][HYST_W-1:0]  hcnt_q;
   logic [NUM_CH-1:0][HYST_W-1:0]  hcnt_d;
   logic [NUM_CH-1:0]              status_q;
   logic [NUM_CH-1:0]              status_d;
   logic                           busy_q;
   logic                           busy_d;

   assign ovr = dla_clk_ovr_on_sync
              | global_clk_ovr_on_sync
              | tmc2slcg_disable_clock_gating;

   // Overrides never touch the counter; it keeps draining underneath.
   always_comb begin
      hcnt_d = hcnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (enable[i]) begin
            hcnt_d[i] = cfg_hyst_cycles;
         end else if (hcnt_q[i] != HZERO) begin
            hcnt_d[i] = hcnt_q[i] - HONE;
         end
      end
   end

   always_comb begin
      clk_en = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         clk_en[i] = ovr
                   | cfg_ch_force_on[i]
                   | enable[i]
                   | (hcnt_q[i] != HZERO);
      end
   end

   always_comb begin
      status_d = clk_en;
      busy_d   = |clk_en;
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         hcnt_q   <= '0;
         status_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         hcnt_q   <= hcnt_d;
         status_q <= status_d;
         busy_q   <= busy_d;
      end
   end

   assign slcg_en_status = status_q;
   assign slcg_busy      = busy_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_gate
      NV_CLK_gate_power u_gate (
         .clk       (nvdla_core_clk),
         .reset_    (nvdla_core_rstn),
         .clk_en    (clk_en[g]),
         .clk_gated (nvdla_core_gated_clk[g])
      );
   end

endmodule
